// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, block/state types and round helper functions
package aes_pkg;

    localparam int NB      = 4;
    localparam int BLOCK_W = 128;

    typedef logic [BLOCK_W-1:0] aes_block_t;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        FINAL,
        DONE
    } aes_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte k of a block sits at [127-8k -: 8]; k = row + 4*column.
    function automatic aes_block_t shift_rows(input aes_block_t s);
        aes_block_t r;
        for (int c = 0; c < NB; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[BLOCK_W-1-8*(row+4*c) -: 8] = s[BLOCK_W-1-8*(row+4*((c+row)%NB)) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0]  a [4];
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            a[i] = col[31-8*i -: 8];
        end
        for (int i = 0; i < 4; i++) begin
            r[31-8*i -: 8] = xtime(a[i]) ^ xtime(a[(i+1)%4]) ^ a[(i+1)%4]
                           ^ a[(i+2)%4] ^ a[(i+3)%4];
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational AES S-box: GF(2^8) inverse followed by the affine map
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse, and maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = x;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    logic [7:0] w_inv;

    assign w_inv  = gf_inv(i_byte);
    assign o_byte = w_inv ^ {w_inv[6:0], w_inv[7]} ^ {w_inv[5:0], w_inv[7:6]}
                  ^ {w_inv[4:0], w_inv[7:5]} ^ {w_inv[3:0], w_inv[7:4]} ^ 8'h63;

endmodule

// File: rtl/aes_round_engine.sv
// rtl/aes_round_engine.sv - iterative AES encryption, one round per clock, valid/ready in and out
// Optional: AES_ROUND_ENGINE_KEY_LATCH_EN captures all round keys on the accept edge.
module aes_round_engine
    import aes_pkg::*;
#(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [BLOCK_W-1:0]          in_block,
    input  logic [(Nr+1)*BLOCK_W-1:0]   words,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [BLOCK_W-1:0]          out_block,
    output logic                        busy
);

    localparam int KEY_W = (Nr+1)*BLOCK_W;

    if (Nk + 6 != Nr) begin : g_cfg_check
        $error("aes_round_engine: Nr must equal Nk+6");
    end

    aes_state_e       r_state;
    aes_state_e       w_state_nxt;
    logic [3:0]       r_round;
    aes_block_t       r_state_reg;
    aes_block_t       r_out_block;
    logic             r_out_valid;
    logic             w_accept;
    logic [KEY_W-1:0] w_keys;
    aes_block_t       w_sub;
    aes_block_t       w_shift;
    aes_block_t       w_mix;
    aes_block_t       w_rk;

    assign w_accept = (r_state == IDLE) & in_valid;

`ifdef AES_ROUND_ENGINE_KEY_LATCH_EN
    logic [KEY_W-1:0] r_keys;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_keys <= '0;
        end else if (w_accept) begin
            r_keys <= words;
        end
    end

    assign w_keys = r_keys;
`else
    assign w_keys = words;
`endif

    for (genvar i = 0; i < 16; i++) begin : g_sbox
        aes_sbox u_sbox (
            .i_byte (r_state_reg[BLOCK_W-1-8*i -: 8]),
            .o_byte (w_sub[BLOCK_W-1-8*i -: 8])
        );
    end

    always_comb begin
        w_shift = shift_rows(w_sub);
        w_mix   = '0;
        for (int c = 0; c < NB; c++) begin
            w_mix[BLOCK_W-1-32*c -: 32] = mix_column(w_shift[BLOCK_W-1-32*c -: 32]);
        end
    end

    always_comb begin
        w_rk = '0;
        for (int r = 0; r <= Nr; r++) begin
            if (r_round == 4'(r)) w_rk = w_keys[KEY_W-1-BLOCK_W*r -: BLOCK_W];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = ROUND;
            ROUND:   if (r_round == 4'(Nr-1)) w_state_nxt = FINAL;
            FINAL:   w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_round     <= '0;
            r_state_reg <= '0;
            r_out_block <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_round <= '0;
                    if (w_accept) begin
                        r_state_reg <= in_block ^ words[KEY_W-1 -: BLOCK_W];
                        r_round     <= 4'd1;
                    end
                end
                ROUND: begin
                    r_state_reg <= w_mix ^ w_rk;
                    r_round     <= r_round + 4'd1;
                end
                FINAL: begin
                    r_out_block <= w_shift ^ w_keys[BLOCK_W-1:0];
                    r_out_valid <= 1'b1;
                    r_round     <= '0;
                end
                DONE: begin
                    r_round <= '0;
                    if (out_ready) r_out_valid <= 1'b0;
                end
                default: r_round <= '0;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE) & ~rst;
    assign busy      = (r_state == ROUND) | (r_state == FINAL);
    assign out_valid = r_out_valid;
    assign out_block = r_out_block;

endmodule

// File: tb/tb_aes_round_engine.sv
// tb/tb_aes_round_engine.sv - directed and random checks of aes_round_engine against a reference AES model
module tb_aes_round_engine;

    localparam int KW10 = 11*128;
    localparam int KW14 = 15*128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [1:0]       in_valid, in_ready, out_valid, out_ready, busy;
    logic [1:0][127:0] in_block, out_block;
    logic [KW10-1:0]  words10;
    logic [KW14-1:0]  words14;

    aes_round_engine #(.Nk(4), .Nr(10)) u_dut10 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_block(in_block[0]), .words(words10), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .out_block(out_block[0]), .busy(busy[0])
    );

    aes_round_engine #(.Nk(8), .Nr(14)) u_dut14 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_block(in_block[1]), .words(words14), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .out_block(out_block[1]), .busy(busy[1])
    );

    int total = 0;
    int bad   = 0;
    logic [7:0] sb [256];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // S-box from exp/log tables over generator 3, then the bitwise affine transform.
    task automatic build_sbox();
        logic [7:0] ex [256];
        int         lg [256];
        logic [7:0] v, inv, s, c;
        c = 8'h63;
        v = 8'h01;
        for (int i = 0; i < 255; i++) begin
            ex[i] = v;
            lg[v] = i;
            v = v ^ {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
        end
        for (int x = 0; x < 256; x++) begin
            inv = (x == 0) ? 8'h00 : ex[(255 - lg[x]) % 255];
            for (int b = 0; b < 8; b++) begin
                s[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8] ^ inv[(b+6)%8] ^ inv[(b+7)%8] ^ c[b];
            end
            sb[x] = s;
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i-8));
        return p[7:0];
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    // Round-key bus right-aligned: rk[0] starts at bit (nr+1)*128-1.
    function automatic logic [KW14-1:0] expand(input logic [255:0] key, input int nk);
        logic [31:0]     w [60];
        logic [31:0]     t;
        logic [7:0]      rc;
        logic [KW14-1:0] bus;
        int              nr;
        nr  = nk + 6;
        rc  = 8'h01;
        bus = '0;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = subword(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int i = 0; i < 4*(nr+1); i++) bus[(nr+1)*128-1-32*i -: 32] = w[i];
        return bus;
    endfunction

    function automatic logic [127:0] aes_ref(input logic [255:0] key, input int nk, input logic [127:0] pt);
        logic [KW14-1:0] bus;
        logic [7:0]      s [16];
        logic [7:0]      t [16];
        logic [127:0]    blk;
        int              nr;
        nr  = nk + 6;
        bus = expand(key, nk);
        blk = pt ^ bus[(nr+1)*128-1 -: 128];
        for (int r = 1; r <= nr; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sb[blk[127-8*i -: 8]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++) t[row+4*c] = s[row+4*((c+row)%4)];
            for (int c = 0; c < 4; c++) begin
                for (int row = 0; row < 4; row++) begin
                    if (r < nr)
                        s[row+4*c] = gmul(8'h02, t[row+4*c]) ^ gmul(8'h03, t[(row+1)%4+4*c])
                                   ^ t[(row+2)%4+4*c] ^ t[(row+3)%4+4*c];
                    else
                        s[row+4*c] = t[row+4*c];
                end
            end
            for (int i = 0; i < 16; i++) blk[127-8*i -: 8] = s[i];
            blk = blk ^ bus[(nr+1)*128-1-128*r -: 128];
        end
        return blk;
    endfunction

    task automatic load_key(input logic [255:0] key, input int d);
        logic [KW14-1:0] bus;
        bus = expand(key, (d == 0) ? 4 : 8);
        if (d == 0) words10 = bus[KW10-1:0];
        else        words14 = bus;
    endtask

    // edges counts the accept edge as 1; the loop stops on out_valid or after 40 edges.
    task automatic encrypt(input int d, input logic [127:0] pt, input int zap_at,
                           output logic [127:0] ct, output int edges);
        int guard;
        guard = 0;
        while (in_ready[d] !== 1'b1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        in_valid[d] = 1'b1;
        in_block[d] = pt;
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
        edges = 1;
        while (out_valid[d] !== 1'b1 && edges < 40) begin
            if (edges == zap_at) begin
                if (d == 0) words10 = '0;
                else        words14 = '0;
            end
            @(posedge clk); #1;
            edges++;
        end
        ct = out_block[d];
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] ct, exp, pt, blk;
        logic [255:0] key;
        logic         ov_seen;
        int           lat;
        localparam logic [127:0] PT_F  = 128'h00112233445566778899aabbccddeeff;
        localparam logic [127:0] CT_F  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        localparam logic [255:0] KEY_F = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};

        build_sbox();
        rst = 1'b1; in_valid = '0; out_ready = 2'b11; in_block = '0;
        words10 = '0; words14 = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_in_ready",  128'(in_ready[0]),  128'd1);
        chk("rst_busy",      128'(busy[0]),      128'd0);
        chk("rst_out_valid", 128'(out_valid[0]), 128'd0);
        chk("rst_out_block", out_block[0],       128'd0);
        chk("rst_in_ready14", 128'(in_ready[1]), 128'd1);

        load_key(KEY_F, 0);
        encrypt(0, PT_F, -1, ct, lat);
        chk("fips128_ct",  ct, CT_F);
        chk("fips128_lat", 128'(lat), 128'd11);

        key = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
        load_key(key, 0);
        encrypt(0, 128'h3243f6a8885a308d313198a2e0370734, -1, ct, lat);
        chk("appb_ct", ct, 128'h3925841d02dc09fbdc118597196a0b32);

        key = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        load_key(key, 1);
        encrypt(1, PT_F, -1, ct, lat);
        chk("fips256_ct",  ct, 128'h8ea2b7ca516745bfeafc49904b496089);
        chk("fips256_lat", 128'(lat), 128'd15);

        // Backpressure: hold the result in DONE while a new block is offered.
        load_key(KEY_F, 0);
        out_ready[0] = 1'b0;
        encrypt(0, PT_F, -1, ct, lat);
        chk("bp_first_ct", ct, CT_F);
        for (int i = 0; i < 5; i++) begin
            in_valid[0] = 1'b1;
            in_block[0] = {$urandom(), $urandom(), $urandom(), $urandom()};
            @(posedge clk); #1;
            chk("bp_out_valid", 128'(out_valid[0]), 128'd1);
            chk("bp_out_block", out_block[0], CT_F);
            chk("bp_in_ready",  128'(in_ready[0]), 128'd0);
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_in_ready",  128'(in_ready[0]),  128'd1);
        chk("bp_release_out_valid", 128'(out_valid[0]), 128'd0);
        chk("bp_release_hold",      out_block[0],       CT_F);
        chk("bp_release_busy",      128'(busy[0]),      128'd0);

        // Abort a block in round 5 with reset.
        in_valid[0] = 1'b1;
        in_block[0] = PT_F;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("abort_busy_before", 128'(busy[0]), 128'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("abort_in_ready",  128'(in_ready[0]),  128'd1);
        chk("abort_busy",      128'(busy[0]),      128'd0);
        chk("abort_out_valid", 128'(out_valid[0]), 128'd0);
        ov_seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (out_valid[0] === 1'b1) ov_seen = 1'b1;
        end
        chk("abort_no_output", 128'(ov_seen), 128'd0);
        encrypt(0, PT_F, -1, ct, lat);
        chk("abort_fresh_ct", ct, CT_F);

        for (int n = 0; n < 4; n++) begin
            key = {$urandom(), $urandom(), $urandom(), $urandom(), 128'h0};
            pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
            load_key(key, 0);
            exp = aes_ref(key, 4, pt);
            encrypt(0, pt, -1, ct, lat);
            chk("rand128_ct", ct, exp);
        end
        for (int n = 0; n < 2; n++) begin
            key = {$urandom(), $urandom(), $urandom(), $urandom(),
                   $urandom(), $urandom(), $urandom(), $urandom()};
            pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
            load_key(key, 1);
            exp = aes_ref(key, 8, pt);
            encrypt(1, pt, -1, ct, lat);
            chk("rand256_ct", ct, exp);
        end

`ifdef AES_ROUND_ENGINE_KEY_LATCH_EN
        load_key(KEY_F, 0);
        encrypt(0, PT_F, 2, ct, lat);
        chk("latch_key_ct",  ct, CT_F);
        chk("latch_key_lat", 128'(lat), 128'd11);
`endif

        blk = out_block[0];
        @(posedge clk); #1;
        chk("idle_hold_block", out_block[0], blk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
